// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin NAND-grant arbiter.
// Grant lines are active-low and one-cold, like a NAND 2-to-4 decoder.
package rr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   localparam logic [NUM_REQ-1:0] GNT_NONE_N = 4'b1111;

   function automatic logic [NUM_REQ-1:0] onecold_n(
      input logic [IDX_W-1:0] idx
   );
      logic [NUM_REQ-1:0] hot;
      hot = '0;
      hot[idx] = 1'b1;
      return ~hot;
   endfunction

endpackage

// File: rtl/rr_nand_grant_arbiter_pick.sv
// Rotating priority pick: scans last_idx+1 .. last_idx+4 (mod 4),
// so the previous winner is always considered last.
module rr_priority_pick
   import rr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_idx,
   output logic               any,
   output logic [IDX_W-1:0]   pick_idx
);

   logic [IDX_W-1:0] cand;

   // Walk from farthest to nearest so the nearest hit wins.
   always_comb begin
      any      = 1'b0;
      pick_idx = last_idx;
      cand     = last_idx;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = last_idx + IDX_W'(i);
         if (req[cand]) begin
            any      = 1'b1;
            pick_idx = cand;
         end
      end
   end

endmodule

// File: rtl/rr_nand_grant_arbiter.sv
// Four-way round-robin arbiter with active-low one-cold grants,
// hold limit, forced release and one-cycle gap. Stats: RR_ARB_STATS_EN.
module rr_nand_grant_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt_n,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_idx,
`ifdef RR_ARB_STATS_EN
   output logic [15:0]        grant_cnt,
   output logic [7:0]         preempt_cnt,
`endif
   output logic               preempt
);

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] last_idx;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             released;
   logic             expired;
   logic             grant_exit;
   logic             grant_enter;
   logic [CNT_W-1:0] hold_nxt;

   rr_priority_pick u_pick (
      .req      (req),
      .last_idx (last_idx),
      .any      (pick_any),
      .pick_idx (pick_idx)
   );

   assign released = ~req[gnt_idx];
   assign expired  = (MAX_HOLD != 0) &&
                     (hold_cnt == CNT_W'(MAX_HOLD));
   assign grant_exit  = (state == GRANT) &&
                        (released || expired);
   assign grant_enter = (state == IDLE || state == GAP) &&
                        pick_any;

   // Saturate so an unlimited tenure never wraps.
   assign hold_nxt = (&hold_cnt) ? hold_cnt
                                 : hold_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt_n     <= GNT_NONE_N;
         gnt_valid <= 1'b0;
         gnt_idx   <= '0;
         preempt   <= 1'b0;
         hold_cnt  <= '0;
         last_idx  <= IDX_W'(NUM_REQ - 1);
      end else begin
         preempt <= 1'b0;
         unique case (state)
            IDLE, GAP: begin
               if (grant_enter) begin
                  state     <= GRANT;
                  gnt_idx   <= pick_idx;
                  gnt_n     <= onecold_n(pick_idx);
                  gnt_valid <= 1'b1;
                  hold_cnt  <= CNT_W'(1);
               end else begin
                  state <= IDLE;
               end
            end
            GRANT: begin
               if (grant_exit) begin
                  state     <= GAP;
                  gnt_n     <= GNT_NONE_N;
                  gnt_valid <= 1'b0;
                  last_idx  <= gnt_idx;
                  preempt   <= expired && !released;
               end else begin
                  hold_cnt <= hold_nxt;
               end
            end
            default: begin
               state     <= IDLE;
               gnt_n     <= GNT_NONE_N;
               gnt_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef RR_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt   <= '0;
         preempt_cnt <= '0;
      end else begin
         if (grant_enter)
            grant_cnt <= grant_cnt + 16'd1;
         if (grant_exit && expired && !released &&
             preempt_cnt != 8'hFF)
            preempt_cnt <= preempt_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rr_nand_grant_arbiter.sv
// Bench: two arbiters (MAX_HOLD=8 and 0) checked against a tenure model.
// Directed scenarios first, then random request traffic.
module tb_rr_nand_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;

   logic [3:0] gnt_n0, gnt_n1;
   logic       v0, v1, p0, p1;
   logic [1:0] idx0, idx1;
`ifdef RR_ARB_STATS_EN
   logic [15:0] gc0, gc1;
   logic [7:0]  pc0, pc1;
`endif

   always #5 clk = ~clk;

   rr_nand_grant_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt_n     (gnt_n0),
      .gnt_valid (v0),
      .gnt_idx   (idx0),
`ifdef RR_ARB_STATS_EN
      .grant_cnt   (gc0),
      .preempt_cnt (pc0),
`endif
      .preempt   (p0)
   );

   rr_nand_grant_arbiter #(.MAX_HOLD(0), .CNT_W(4)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt_n     (gnt_n1),
      .gnt_valid (v1),
      .gnt_idx   (idx1),
`ifdef RR_ARB_STATS_EN
      .grant_cnt   (gc1),
      .preempt_cnt (pc1),
`endif
      .preempt   (p1)
   );

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 granted, 2 gap.
   int m_phase [2];
   int m_own   [2];
   int m_last  [2];
   int m_len   [2];
   int m_pre   [2];
   int m_gc    [2];
   int m_pc    [2];
   int m_mh    [2] = '{8, 0};

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   function automatic int pick(input int last,
                               input logic [3:0] r);
      for (int off = 1; off <= 4; off++)
         if (r[(last + off) % 4]) return (last + off) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_phase[k] = 0; m_own[k] = 0; m_last[k] = 3;
         m_len[k] = 0; m_pre[k] = 0;
         m_gc[k] = 0; m_pc[k] = 0;
      end
   endtask

   task automatic model_edge(input logic [3:0] r);
      int p;
      for (int k = 0; k < 2; k++) begin
         m_pre[k] = 0;
         if (m_phase[k] == 1) begin
            if (!r[m_own[k]] || (m_mh[k] != 0 && m_len[k] == m_mh[k])) begin
               m_pre[k] = r[m_own[k]] ? 1 : 0;
               if (m_pre[k] == 1 && m_pc[k] < 255) m_pc[k]++;
               m_last[k] = m_own[k];
               m_phase[k] = 2;
            end else if (m_len[k] < 15) begin
               m_len[k]++;
            end
         end else begin
            p = pick(m_last[k], r);
            if (p >= 0) begin
               m_own[k] = p; m_len[k] = 1;
               m_phase[k] = 1; m_gc[k]++;
            end else begin
               m_phase[k] = 0;
            end
         end
      end
   endtask

   function automatic logic [7:0] expv(input int k);
      logic [3:0] g;
      g = 4'b1111;
      if (m_phase[k] == 1) g[m_own[k]] = 1'b0;
      return {g, m_phase[k] == 1, 2'(m_own[k]), m_pre[k] == 1};
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "/h8"}, {8'h0, gnt_n0, v0, idx0, p0}, {8'h0, expv(0)});
      chk({tag, "/h0"}, {8'h0, gnt_n1, v1, idx1, p1}, {8'h0, expv(1)});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge(req);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 4'b0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst_n = 1'b1;
   endtask

   int order [$];
   int npre;
   int tlen;
   int tlens [$];

   initial begin
      do_reset();
      chk("rst_gnt_n", {12'h0, gnt_n0}, 16'hF);

      // Single requester, grant after one edge, release, gap, idle.
      req = 4'b0001;
      step("t1_grant");
      chk("t1_gnt_n", {12'h0, gnt_n0}, 16'hE);
      req = 4'b0000;
      step("t1_gap");
      chk("t1_gap_n", {12'h0, gnt_n0}, 16'hF);
      step("t1_idle");

      // All requesting: forced rotation on dut0, locked grant on dut1.
      do_reset();
      req = 4'b1111;
      npre = 0;
      tlen = 0;
      for (int i = 0; i < 45; i++) begin
         step("t2_rot");
         if (v0) begin
            if (tlen == 0) order.push_back(int'(idx0));
            tlen++;
         end else if (tlen != 0) begin
            tlens.push_back(tlen);
            tlen = 0;
         end
         if (p0) npre++;
         chk("t2_h0_idx", {14'h0, idx1}, 16'h0);
         chk("t2_h0_pre", {15'h0, p1}, 16'h0);
      end
      chk("t2_order_n", 16'(order.size()), 16'd5);
      for (int i = 0; i < order.size() && i < 5; i++)
         chk("t2_order", 16'(order[i]), 16'(i % 4));
      foreach (tlens[i])
         chk("t2_tenure", 16'(tlens[i]), 16'd8);
      chk("t2_preempts", 16'(npre), 16'd5);
`ifdef RR_ARB_STATS_EN
      chk("t2_grant_cnt", gc0, 16'd5);
      chk("t2_pre_cnt", {8'h0, pc0}, 16'd5);
`endif

      // Release coinciding with expiry on requester 2.
      do_reset();
      req = 4'b0100;
      step("t3_grant");
      chk("t3_gnt_n", {12'h0, gnt_n0}, 16'hB);
      repeat (7) step("t3_hold");
      req = 4'b1001;
      step("t3_exit");
      chk("t3_no_pre", {15'h0, p0}, 16'h0);
      step("t3_next");
      chk("t3_next_idx", {14'h0, idx0}, 16'h3);

      // Asynchronous reset while granting requester 2.
      do_reset();
      req = 4'b0100;
      step("t4_grant");
      chk("t4_pre_rst", {12'h0, gnt_n0}, 16'hB);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t4_async_n", {12'h0, gnt_n0}, 16'hF);
      chk("t4_async_v", {15'h0, v0}, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1000;
      step("t4_after");
      chk("t4_idx3", {14'h0, idx0}, 16'h3);

      // Two low requesters held on the unlimited instance.
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 50; i++) begin
         step("t5_hold");
         if (i > 0) chk("t5_gnt_n", {12'h0, gnt_n1}, 16'hE);
      end

      // Random traffic with sticky requests.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)
            req = 4'($urandom_range(0, 15));
         step("rand");
      end
`ifdef RR_ARB_STATS_EN
      chk("rand_gc0", gc0, 16'(m_gc[0]));
      chk("rand_pc0", {8'h0, pc0}, 16'(m_pc[0]));
      chk("rand_gc1", gc1, 16'(m_gc[1]));
      chk("rand_pc1", {8'h0, pc1}, 16'(m_pc[1]));
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
